// File: rtl/fpu_pkg.sv
// Shared FPU definitions: IEEE-754 single field widths, bias, canonical NaN,
// divider state encoding and the per-operand class record.
package fpu_pkg;

  localparam int SIGN_W   = 1;
  localparam int EXP_W    = 8;
  localparam int MANT_W   = 23;
  localparam int EXP_BIAS = 127;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  // Quotient bits produced by the divide loop: 24 significand bits + guard.
  localparam int DIV_STEPS = 25;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PREP  = 2'd1,
    ST_DIV   = 2'd2,
    ST_ROUND = 2'd3
  } div_state_t;

  typedef struct packed {
    logic is_zero;  // true zero or denormal (flushed to zero)
    logic is_inf;
    logic is_nan;
    logic is_norm;
  } fp_class_t;

endpackage

// File: rtl/fpu_classify.sv
// Combinational operand classifier, shared by the FPU units.
// Denormals report as zero because the FPU flushes them.
module fpu_classify
  import fpu_pkg::*;
(
  input  logic [EXP_W-1:0]  exp,
  input  logic [MANT_W-1:0] frac,
  output fp_class_t         cls
);

  // Decode exponent/fraction into exactly one class.
  always_comb begin
    // NOTE: every field gets a default first so no path can infer a latch.
    cls = '0;
    if (exp == '0) begin
      cls.is_zero = 1'b1;
    end else if (exp == '1) begin
      cls.is_inf = (frac == '0);
      cls.is_nan = (frac != '0);
    end else begin
      cls.is_norm = 1'b1;
    end
  end

endmodule

// File: rtl/fpu_div.sv
// Multi-cycle IEEE-754 single-precision divider: restoring loop, one quotient
// bit per cycle, round-to-nearest-even, flush-to-zero, fixed 28-edge latency.
module fpu_div
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] ope1,
  input  logic [31:0] ope2,
  output logic        busy,
  output logic        valid,
  output logic [31:0] q
);

  div_state_t        state;
  logic [4:0]        cnt;        // remaining divide steps
  logic [31:0]       a_reg;
  logic [31:0]       b_reg;
  logic              sign;
  logic signed [9:0] e;
  logic [24:0]       rem;
  logic [23:0]       dvs;
  logic [24:0]       quo;
  logic              is_special;
  logic [31:0]       special_q;

  fp_class_t a_cls;
  fp_class_t b_cls;

  fpu_classify u_cls_a (.exp(a_reg[30:23]), .frac(a_reg[22:0]), .cls(a_cls));
  fpu_classify u_cls_b (.exp(b_reg[30:23]), .frac(b_reg[22:0]), .cls(b_cls));

  logic [23:0]       m1;
  logic [23:0]       m2;
  logic signed [9:0] e_pre;
  logic              res_sign;
  logic [31:0]       special_res;
  logic              rem_ge;
  logic [24:0]       rem_sel;
  logic [24:0]       rem_next;
  logic [24:0]       rnd;
  logic signed [9:0] e_fin;
  logic [22:0]       mant_fin;
  logic [31:0]       result;

  assign m1       = {1'b1, a_reg[22:0]};
  assign m2       = {1'b1, b_reg[22:0]};
  assign res_sign = a_reg[31] ^ b_reg[31];
  assign e_pre    = $signed({2'b00, a_reg[30:23]}) - $signed({2'b00, b_reg[30:23]})
                  + $signed(10'(EXP_BIAS));

  // Special-case result; only used when either operand is not a normal number.
  always_comb begin
    special_res = {res_sign, 31'd0};
    if (a_cls.is_nan || b_cls.is_nan || (a_cls.is_zero && b_cls.is_zero) ||
        (a_cls.is_inf && b_cls.is_inf))
      special_res = QNAN;
    else if (a_cls.is_inf || b_cls.is_zero)
      special_res = {res_sign, 8'hFF, 23'd0};
  end

  // One restoring step: subtract when it fits, record the bit, shift left.
  always_comb begin
    rem_ge   = (rem >= {1'b0, dvs});
    rem_sel  = rem_ge ? (rem - {1'b0, dvs}) : rem;
    rem_next = rem_sel << 1;
  end

  // Round to nearest-even on guard/sticky, renormalise, saturate the exponent.
  always_comb begin
    rnd      = {1'b0, quo[24:1]} + 25'(quo[0] & ((rem != '0) | quo[1]));
    e_fin    = rnd[24] ? e + 10'sd1 : e;
    mant_fin = rnd[24] ? rnd[23:1] : rnd[22:0];
    if (is_special)
      result = special_q;
    else if (e_fin >= 10'sd255)
      result = {sign, 8'hFF, 23'd0};
    else if (e_fin <= 10'sd0)
      result = {sign, 31'd0};
    else
      result = {sign, e_fin[7:0], mant_fin};
  end

  // Control FSM and datapath registers; reset wins over everything.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    if (rst) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      valid      <= 1'b0;
      q          <= '0;
      cnt        <= '0;
      rem        <= '0;
      quo        <= '0;
      dvs        <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      sign       <= 1'b0;
      e          <= '0;
      is_special <= 1'b0;
      special_q  <= '0;
    end else begin
      valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_reg <= ope1;
            b_reg <= ope2;
            busy  <= 1'b1;
            state <= ST_PREP;
          end
        end
        ST_PREP: begin
          sign       <= res_sign;
          dvs        <= m2;
          quo        <= '0;
          is_special <= ~(a_cls.is_norm & b_cls.is_norm);
          special_q  <= special_res;
          // Pre-align so the first quotient bit is always the integer 1.
          if (m1 < m2) begin
            rem <= {m1, 1'b0};
            e   <= e_pre - 10'sd1;
          end else begin
            rem <= {1'b0, m1};
            e   <= e_pre;
          end
          cnt   <= 5'(DIV_STEPS);
          state <= ST_DIV;
        end
        ST_DIV: begin
          if (cnt != '0) begin
            rem <= rem_next;
            quo <= {quo[23:0], rem_ge};
            cnt <= cnt - 5'd1;
          end else begin
            // Extra cycle here keeps latency fixed at 28 edges for all classes.
            state <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          q     <= result;
          valid <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_div.sv
// Self-checking bench for fpu_div: directed cases, start/reset corner cases
// and randomized operands against an exact-integer reference divider.
module tb_fpu_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] ope1;
  logic [31:0] ope2;
  logic        busy;
  logic        valid;
  logic [31:0] q;

  int n_cmp   = 0;
  int n_fail  = 0;
  int n_valid = 0;
  int cyc     = 0;

  fpu_div dut (
    .clk(clk), .rst(rst), .start(start), .ope1(ope1), .ope2(ope2),
    .busy(busy), .valid(valid), .q(q)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Count every valid pulse; valid is high for one full cycle.
  always @(negedge clk) if (valid) n_valid <= n_valid + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Reference: exact integer quotient of the significands, then RNE.
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    logic s;
    int ea, eb, e;
    bit [63:0] num, qq, r, mant;
    bit g, st;
    bit a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    a_zero = (ea == 0);
    b_zero = (eb == 0);
    a_inf  = (ea == 255) && (a[22:0] == 0);
    b_inf  = (eb == 255) && (b[22:0] == 0);
    a_nan  = (ea == 255) && (a[22:0] != 0);
    b_nan  = (eb == 255) && (b[22:0] != 0);
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) return 32'h7FC00000;
    if (a_inf || b_zero) return {s, 8'hFF, 23'd0};
    if (a_zero || b_inf) return {s, 31'd0};
    num = 64'({1'b1, a[22:0]}) << 25;
    qq  = num / 64'({1'b1, b[22:0]});
    r   = num % 64'({1'b1, b[22:0]});
    e   = ea - eb + 127;
    if (qq >= (64'd1 << 25)) begin
      mant = qq >> 2;
      g    = qq[1];
      st   = qq[0] || (r != 0);
    end else begin
      e    = e - 1;
      mant = qq >> 1;
      g    = qq[0];
      st   = (r != 0);
    end
    if (g && (st || mant[0])) mant = mant + 1;
    if (mant == (64'd1 << 24)) begin
      mant = mant >> 1;
      e    = e + 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'd0};
    if (e <= 0) return {s, 31'd0};
    return {s, 8'(e), mant[22:0]};
  endfunction

  function automatic logic [31:0] gen_op();
    logic [31:0] v;
    int sel;
    v   = $urandom;
    sel = $urandom_range(0, 11);
    case (sel)
      0: v[30:0] = '0;
      1: v[30:0] = {8'hFF, 23'd0};
      2: v[30:0] = {8'hFF, v[22:1], 1'b1};
      3: v[30:23] = 8'h00;
      4: v[30:23] = 8'(($urandom_range(0, 1) != 0) ? $urandom_range(230, 254) : $urandom_range(1, 25));
      default: v[30:23] = 8'($urandom_range(100, 154));
    endcase
    return v;
  endfunction

  // Launch one divide and wait for valid; lat = edges from the sampling edge.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    int c0;
    @(negedge clk);
    ope1  = a;
    ope2  = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    c0    = cyc;
    start = 1'b0;
    lat   = -1;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (valid) begin
        lat = cyc - c0;
        break;
      end
    end
    res = q;
  endtask

  logic [31:0] res;
  logic [31:0] held;
  int          lat;
  int          c0;
  int          v0;

  initial begin
    // Reset with start asserted: reset must win and nothing may launch.
    rst   = 1'b1;
    start = 1'b1;
    ope1  = 32'h41200000;
    ope2  = 32'h40200000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_q", q, 32'h0);
    check("reset_no_launch", 32'(n_valid), 32'd0);

    // 10.0 / 2.5 with latency and busy during the operation.
    @(negedge clk);
    ope1  = 32'h41200000;
    ope2  = 32'h40200000;
    start = 1'b1;
    @(posedge clk);
    #1;
    c0    = cyc;
    start = 1'b0;
    @(negedge clk);
    check("busy_during", 32'(busy), 32'd1);
    lat = -1;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (valid) begin
        lat = cyc - c0;
        break;
      end
    end
    check("div_10_2p5", q, 32'h40800000);
    check("latency_10_2p5", 32'(lat), 32'd28);
    held = q;
    repeat (5) @(negedge clk);
    check("q_held", q, held);
    check("valid_pulse_once", 32'(valid), 32'd0);
    check("busy_after", 32'(busy), 32'd0);

    // 1/3 exercises round-up on guard with nonzero sticky.
    do_div(32'h3F800000, 32'h40400000, res, lat);
    check("div_1_3", res, 32'h3EAAAAAB);

    // Special cases, overflow and underflow: same fixed latency.
    do_div(32'h3F800000, 32'h00000000, res, lat);
    check("div_x_0", res, 32'h7F800000);
    check("latency_special", 32'(lat), 32'd28);
    do_div(32'h00000000, 32'h00000000, res, lat);
    check("div_0_0", res, 32'h7FC00000);
    do_div(32'hC0000000, 32'h7F800000, res, lat);
    check("div_fin_inf", res, 32'h80000000);
    do_div(32'h7F000000, 32'h3E800000, res, lat);
    check("overflow", res, 32'h7F800000);
    do_div(32'h00800000, 32'h40000000, res, lat);
    check("underflow", res, 32'h00000000);

    // Start during busy is ignored; start in the valid cycle is accepted.
    v0 = n_valid;
    @(negedge clk);
    ope1  = 32'h40E00000;  // 7.0
    ope2  = 32'h40000000;  // 2.0
    start = 1'b1;
    @(posedge clk);
    #1;
    c0    = cyc;
    start = 1'b0;
    lat   = -1;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (valid) begin
        lat = cyc - c0;
        break;
      end
      if (i == 5) begin
        ope1  = 32'h42C80000;  // 100.0
        ope2  = 32'h40A00000;  // 5.0
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    check("busy_start_result", q, 32'h40600000);
    check("busy_start_latency", 32'(lat), 32'd28);
    // Still inside the valid cycle: request the next divide now.
    ope1  = 32'h42C80000;
    ope2  = 32'h40A00000;
    start = 1'b1;
    @(posedge clk);
    #1;
    c0    = cyc;
    start = 1'b0;
    lat   = -1;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (valid) begin
        lat = cyc - c0;
        break;
      end
    end
    check("valid_cycle_start", q, 32'h41A00000);
    check("valid_cycle_latency", 32'(lat), 32'd28);
    @(negedge clk);
    check("busy_start_pulses", 32'(n_valid - v0), 32'd2);

    // Reset 10 cycles into a divide: aborted, never reported.
    @(negedge clk);
    ope1  = 32'h40400000;
    ope2  = 32'h3F800000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(valid), 32'd0);
    check("abort_q", q, 32'h0);
    rst = 1'b0;
    v0  = n_valid;
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("abort_no_valid", 32'(n_valid - v0), 32'd0);
    check("abort_q_kept", q, 32'h0);

    // Randomized operands against the reference model.
    for (int k = 0; k < 40; k++) begin
      logic [31:0] a, b;
      a = gen_op();
      b = gen_op();
      do_div(a, b, res, lat);
      check($sformatf("rand%0d %h/%h", k, a, b), res, ref_div(a, b));
      check($sformatf("rand%0d_latency", k), 32'(lat), 32'd28);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
